// File: rtl/fifo_n_oc.sv
// Parameterised circular-buffer FIFO with guarded enq/deq/first methods and an occupancy count.
// Optional macro FIFO_N_OC_PIPELINE_EN lets a full FIFO take an enqueue alongside a same-cycle dequeue.
module fifo_n_oc #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_enq__ENA,
    input  logic [WIDTH-1:0] in_enq_v,
    output logic             in_enq__RDY,
    input  logic             out_deq__ENA,
    output logic             out_deq__RDY,
    output logic [WIDTH-1:0] out_first,
    output logic             out_first__RDY,
    output logic [CW-1:0]    out_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_nonempty;
    logic w_enq;
    logic w_deq;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_nonempty = (r_count != '0);

`ifdef FIFO_N_OC_PIPELINE_EN
    // A full FIFO can still accept when the head leaves this cycle; the
    // write lands in the slot being vacated since wp == rp when full.
    assign in_enq__RDY = !w_full || out_deq__ENA;
`else
    assign in_enq__RDY = !w_full;
`endif

    assign out_deq__RDY   = w_nonempty;
    assign out_first__RDY = w_nonempty;
    assign out_first      = r_mem[r_rp];
    assign out_count      = r_count;

    assign w_enq = in_enq__ENA  && in_enq__RDY;
    assign w_deq = out_deq__ENA && w_nonempty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_wp] <= in_enq_v;
                r_wp        <= r_wp + PW'(1);
            end
            if (w_deq) r_rp <= r_rp + PW'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_n_oc.sv
// Self-checking bench for fifo_n_oc: directed scenarios plus random traffic against a queue model.
module tb_fifo_n_oc;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);
`ifdef FIFO_N_OC_PIPELINE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enq_ena = 1'b0;
    logic [W-1:0]  enq_v = '0;
    logic          enq_rdy;
    logic          deq_ena = 1'b0;
    logic          deq_rdy;
    logic [W-1:0]  first;
    logic          first_rdy;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q [$];
    int           enq_since_rst = 0;

    always #5 clk = ~clk;

    fifo_n_oc #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK            (clk),
        .RST            (rst),
        .in_enq__ENA    (enq_ena),
        .in_enq_v       (enq_v),
        .in_enq__RDY    (enq_rdy),
        .out_deq__ENA   (deq_ena),
        .out_deq__RDY   (deq_rdy),
        .out_first      (first),
        .out_first__RDY (first_rdy),
        .out_count      (count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_enq_rdy(input logic d);
        return (q.size() != D) || (PIPE && d);
    endfunction

    // Compare every output with the model; called away from the clock edge.
    task automatic check_all(input string tag);
        chk({tag, ".count"},     64'(count),     64'(q.size()));
        chk({tag, ".deq_rdy"},   64'(deq_rdy),   64'(q.size() != 0));
        chk({tag, ".first_rdy"}, 64'(first_rdy), 64'(q.size() != 0));
        chk({tag, ".enq_rdy"},   64'(enq_rdy),   64'(exp_enq_rdy(deq_ena)));
        if (q.size() != 0)
            chk({tag, ".first"}, 64'(first), 64'(q[0]));
        else if (enq_since_rst < D)
            chk({tag, ".first_stale"}, 64'(first), 64'd0);
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic cycle(input logic e, input logic [W-1:0] v, input logic d, input logic r,
                         input string tag);
        logic en_ok, de_ok;
        enq_ena = e; enq_v = v; deq_ena = d; rst = r;
        #1;
        if (!r) chk({tag, ".enq_rdy_comb"}, 64'(enq_rdy), 64'(exp_enq_rdy(d)));
        en_ok = e && exp_enq_rdy(d);
        de_ok = d && (q.size() != 0);
        @(posedge clk);
        if (r) begin
            q.delete();
            enq_since_rst = 0;
        end else begin
            if (de_ok) void'(q.pop_front());
            if (en_ok) begin
                q.push_back(v);
                enq_since_rst++;
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, '0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        @(negedge clk);
        cycle(1'b0, '0, 1'b0, 1'b1, "rst");
        cycle(1'b1, 32'hDEAD, 1'b1, 1'b1, "rst2");
        idle("idle");
        chk("rst.first", 64'(first), 64'd0);
        chk("rst.enq_rdy", 64'(enq_rdy), 64'd1);

        // Fill to DEPTH, then an extra enqueue that must be ignored.
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(32'h11 * (i + 1)), 1'b0, 1'b0, "fill");
        chk("full.count", 64'(count), 64'd4);
        chk("full.enq_rdy", 64'(enq_rdy), 64'd0);
        chk("full.first", 64'(first), 64'h11);
        cycle(1'b1, 32'h55, 1'b0, 1'b0, "fifth");
        chk("fifth.count", 64'(count), 64'd4);

        for (int i = 0; i < 4; i++) begin
            chk("drain.first", 64'(first), 64'(32'h11 * (i + 1)));
            cycle(1'b0, '0, 1'b1, 1'b0, "drain");
        end

        // Ten values through the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, W'(32'hA0 + i), 1'b0, 1'b0, "wrap.enq");
            chk("wrap.first", 64'(first), 64'(32'hA0 + i));
            cycle(1'b0, '0, 1'b1, 1'b0, "wrap.deq");
        end
        chk("wrap.deq_rdy", 64'(deq_rdy), 64'd0);

        // Simultaneous enq+deq at count 2.
        cycle(1'b1, 32'hB0, 1'b0, 1'b0, "mid.enq");
        cycle(1'b1, 32'hB1, 1'b0, 1'b0, "mid.enq");
        for (int i = 0; i < 3; i++) cycle(1'b1, W'(32'hB2 + i), 1'b1, 1'b0, "mid.both");
        chk("mid.count", 64'(count), 64'd2);
        chk("mid.first", 64'(first), 64'hB3);
        while (q.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0, "mid.drain");

        // Empty with both ENA: only the enqueue happens.
        cycle(1'b1, 32'hC0, 1'b1, 1'b0, "empty.both");
        chk("empty.both.count", 64'(count), 64'd1);
        chk("empty.both.first", 64'(first), 64'hC0);
        cycle(1'b0, '0, 1'b1, 1'b0, "empty.drain");

        // Full with both ENA.
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(32'hD0 + i), 1'b0, 1'b0, "full2");
        cycle(1'b1, 32'h99, 1'b1, 1'b0, "full.both");
        chk("full.both.count", 64'(count), PIPE ? 64'd4 : 64'd3);
        chk("full.both.first", 64'(first), 64'hD1);
        while (q.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0, "full.drain");

        // Reset while count = 3 with both ENA high.
        for (int i = 0; i < 3; i++) cycle(1'b1, W'(32'hE0 + i), 1'b0, 1'b0, "pre.rst");
        cycle(1'b1, 32'h77, 1'b1, 1'b1, "mid.rst");
        chk("mid.rst.count", 64'(count), 64'd0);
        chk("mid.rst.first", 64'(first), 64'd0);
        cycle(1'b1, 32'h5A, 1'b0, 1'b0, "post.rst");
        chk("post.rst.first", 64'(first), 64'h5A);

        // Random traffic with occasional reset.
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom_range(0, 2) != 0), W'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 63) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
